// File: rtl/ads868x_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ads868x_spi_arbiter
// Brief    : Shares one ADS868x SPI byte-stream engine between a high-priority
//            sequencer port (A) and a host port (B); frames 1-4 byte transfers
//            and returns the collected RX bytes to the owning port.
// Revision : 1.0 - initial release
// ============================================================================
module ads868x_spi_arbiter #(
    parameter int C_TIMEOUT_CYCLES = 4096
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic [1:0]  a_req_nbytes,
    input  logic [31:0] a_req_data,
    output logic [31:0] a_rsp_data,
    output logic        a_rsp_valid,
    output logic        a_rsp_err,

    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic [1:0]  b_req_nbytes,
    input  logic [31:0] b_req_data,
    output logic [31:0] b_rsp_data,
    output logic        b_rsp_valid,
    output logic        b_rsp_err,

    output logic [7:0]  spi_tx_tdata,
    output logic        spi_tx_tvalid,
    input  logic        spi_tx_tready,
    input  logic [7:0]  spi_rx_tdata,
    input  logic        spi_rx_tvalid,
    output logic        spi_rx_tready,

    output logic        stat_busy,
    output logic        stat_owner,
    output logic [7:0]  stat_timeout_cnt,
    output logic [7:0]  stat_stray_cnt
);

    localparam int                c_WD_W    = $clog2(C_TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(C_TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_owner;
    logic [2:0]         r_n;
    logic [2:0]         r_tx_cnt;
    logic [2:0]         r_rx_cnt;
    logic [31:0]        r_tx_shift;
    logic [31:0]        r_rx_shift;
    logic [c_WD_W-1:0]  r_wd;
    logic [31:0]        r_a_rsp_data;
    logic               r_a_rsp_valid;
    logic               r_a_rsp_err;
    logic [31:0]        r_b_rsp_data;
    logic               r_b_rsp_valid;
    logic               r_b_rsp_err;
    logic [7:0]         r_timeout_cnt;
    logic [7:0]         r_stray_cnt;

    logic               w_idle;
    logic               w_sel_b;
    logic [1:0]         w_nb;
    logic [31:0]        w_data;
    logic [31:0]        w_tx_init;
    logic               w_tx_hs;
    logic               w_rx_hs;
    logic [31:0]        w_rx_next;
    logic               w_rx_last;
    logic               w_wd_exp;
    logic               w_done;
    logic [31:0]        w_rsp_data;
    logic               w_rsp_err;

    assign w_idle      = (r_state == S_IDLE);
    assign a_req_ready = w_idle;
    assign b_req_ready = w_idle && !a_req_valid;

    // A always wins a simultaneous request, so B is selected only when A is quiet.
    assign w_sel_b   = !a_req_valid;
    assign w_nb      = w_sel_b ? b_req_nbytes : a_req_nbytes;
    assign w_data    = w_sel_b ? b_req_data   : a_req_data;
    assign w_tx_init = w_data << {2'd3 - w_nb, 3'b000};

    assign spi_tx_tvalid = (r_state == S_XFER) && (r_tx_cnt != r_n);
    assign spi_tx_tdata  = r_tx_shift[31:24];
    assign spi_rx_tready = !areset;

    assign w_tx_hs    = spi_tx_tvalid && spi_tx_tready;
    assign w_rx_hs    = spi_rx_tvalid && spi_rx_tready;
    assign w_rx_next  = {r_rx_shift[23:0], spi_rx_tdata};
    assign w_rx_last  = w_rx_hs && (r_rx_cnt == (r_n - 3'd1));
    assign w_wd_exp   = (r_wd == c_WD_LAST);
    assign w_done     = w_rx_last || w_wd_exp;
    // Completion takes precedence over a coincident watchdog expiry.
    assign w_rsp_err  = !w_rx_last;
    assign w_rsp_data = w_rx_last ? w_rx_next : 32'd0;

    assign stat_busy        = !w_idle;
    assign stat_owner       = r_owner;
    assign stat_timeout_cnt = r_timeout_cnt;
    assign stat_stray_cnt   = r_stray_cnt;
    assign a_rsp_data       = r_a_rsp_data;
    assign a_rsp_valid      = r_a_rsp_valid;
    assign a_rsp_err        = r_a_rsp_err;
    assign b_rsp_data       = r_b_rsp_data;
    assign b_rsp_valid      = r_b_rsp_valid;
    assign b_rsp_err        = r_b_rsp_err;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_n           <= 3'd0;
            r_tx_cnt      <= 3'd0;
            r_rx_cnt      <= 3'd0;
            r_tx_shift    <= 32'd0;
            r_rx_shift    <= 32'd0;
            r_wd          <= '0;
            r_a_rsp_data  <= 32'd0;
            r_a_rsp_valid <= 1'b0;
            r_a_rsp_err   <= 1'b0;
            r_b_rsp_data  <= 32'd0;
            r_b_rsp_valid <= 1'b0;
            r_b_rsp_err   <= 1'b0;
            r_timeout_cnt <= 8'd0;
            r_stray_cnt   <= 8'd0;
        end else begin
            r_a_rsp_valid <= 1'b0;
            r_b_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rx_hs && (r_stray_cnt != 8'hFF)) begin
                        r_stray_cnt <= r_stray_cnt + 8'd1;
                    end
                    if (a_req_valid || b_req_valid) begin
                        r_owner    <= w_sel_b;
                        r_n        <= {1'b0, w_nb} + 3'd1;
                        r_tx_shift <= w_tx_init;
                        r_rx_shift <= 32'd0;
                        r_tx_cnt   <= 3'd0;
                        r_rx_cnt   <= 3'd0;
                        r_wd       <= '0;
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    r_wd <= r_wd + c_WD_ONE;
                    if (w_tx_hs) begin
                        r_tx_shift <= {r_tx_shift[23:0], 8'd0};
                        r_tx_cnt   <= r_tx_cnt + 3'd1;
                    end
                    if (w_rx_hs) begin
                        r_rx_shift <= w_rx_next;
                        r_rx_cnt   <= r_rx_cnt + 3'd1;
                    end
                    if (w_done) begin
                        r_state <= S_RESP;
                        if (r_owner) begin
                            r_b_rsp_valid <= 1'b1;
                            r_b_rsp_data  <= w_rsp_data;
                            r_b_rsp_err   <= w_rsp_err;
                        end else begin
                            r_a_rsp_valid <= 1'b1;
                            r_a_rsp_data  <= w_rsp_data;
                            r_a_rsp_err   <= w_rsp_err;
                        end
                        if (w_rsp_err && (r_timeout_cnt != 8'hFF)) begin
                            r_timeout_cnt <= r_timeout_cnt + 8'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (w_rx_hs && (r_stray_cnt != 8'hFF)) begin
                        r_stray_cnt <= r_stray_cnt + 8'd1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ads868x_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads868x_spi_arbiter
// Brief    : Self-checking bench: SPI loopback responder plus a timestamp-based
//            transaction model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ads868x_spi_arbiter;

    localparam int c_TIMEOUT = 16;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic [1:0]  a_req_nbytes = 2'd0, b_req_nbytes = 2'd0;
    logic [31:0] a_req_data = 32'd0, b_req_data = 32'd0;
    logic        spi_tx_tready = 1'b0;
    logic [7:0]  spi_rx_tdata = 8'd0;
    logic        spi_rx_tvalid = 1'b0;
    logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err;
    logic [31:0] a_rsp_data, b_rsp_data;
    logic [7:0]  spi_tx_tdata, stat_timeout_cnt, stat_stray_cnt;
    logic        spi_tx_tvalid, spi_rx_tready, stat_busy, stat_owner;

    ads868x_spi_arbiter #(.C_TIMEOUT_CYCLES(c_TIMEOUT)) u_dut (
        .aclk(aclk), .areset(areset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_nbytes(a_req_nbytes),
        .a_req_data(a_req_data), .a_rsp_data(a_rsp_data), .a_rsp_valid(a_rsp_valid), .a_rsp_err(a_rsp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_nbytes(b_req_nbytes),
        .b_req_data(b_req_data), .b_rsp_data(b_rsp_data), .b_rsp_valid(b_rsp_valid), .b_rsp_err(b_rsp_err),
        .spi_tx_tdata(spi_tx_tdata), .spi_tx_tvalid(spi_tx_tvalid), .spi_tx_tready(spi_tx_tready),
        .spi_rx_tdata(spi_rx_tdata), .spi_rx_tvalid(spi_rx_tvalid), .spi_rx_tready(spi_rx_tready),
        .stat_busy(stat_busy), .stat_owner(stat_owner),
        .stat_timeout_cnt(stat_timeout_cnt), .stat_stray_cnt(stat_stray_cnt)
    );

    always #5 aclk = ~aclk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic rst_q    = 1'b1;

    always @(posedge aclk) begin
        cyc   <= cyc + 1;
        rst_q <= areset;
    end

    // Per-port request description consumed at accept time.
    logic [1:0]  p_nb   [2];
    logic [31:0] p_data [2];
    logic [7:0]  p_rx   [2][4];
    bit          p_rx_en[2];

    bit          m_fl = 0, m_xfer = 0, m_err = 0;
    int          m_port = 0, m_n = 0, t_acc = 0, t_rsp = -1, tx_sent = 0, rx_got = 0;
    logic [31:0] m_rsp = 32'd0;
    logic [7:0]  exp_tx[$], rx_q[$], stray_q[$];
    int          m_to = 0, m_stray = 0, stall = 0;
    bit          acc_a = 0, acc_b = 0, rnd_tready = 0, rnd_rx = 0;
    int          pulses[2] = '{0, 0};
    int          exp_pulses[2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    endtask

    task automatic set_req(input int p, input logic [1:0] nb, input logic [31:0] d,
                           input logic [31:0] rxw, input bit rx_en);
        p_nb[p] = nb; p_data[p] = d; p_rx_en[p] = rx_en;
        for (int i = 0; i < 4; i++) p_rx[p][i] = rxw[31-8*i -: 8];
        if (p == 0) begin a_req_nbytes = nb; a_req_data = d; end
        else        begin b_req_nbytes = nb; b_req_data = d; end
    endtask

    task automatic accept(input int p);
        m_fl = 1; m_xfer = 1; m_port = p; m_n = int'(p_nb[p]) + 1;
        t_acc = cyc; t_rsp = -1; tx_sent = 0; rx_got = 0; m_rsp = 32'd0;
        exp_tx.delete(); rx_q.delete();
        for (int i = m_n - 1; i >= 0; i--) exp_tx.push_back(p_data[p][8*i +: 8]);
        if (p_rx_en[p]) for (int i = 0; i < m_n; i++) rx_q.push_back(p_rx[p][i]);
        if (p == 0) acc_a = 1; else acc_b = 1;
    endtask

    task automatic observe();
        bit busy, tx_hs, rx_hs;
        busy  = m_fl && (cyc > t_acc);
        tx_hs = spi_tx_tvalid && spi_tx_tready;
        rx_hs = spi_rx_tvalid && spi_rx_tready;
        if (rst_q) begin
            chk("rst_a_rsp_data", a_rsp_data, 32'd0);
            chk("rst_b_rsp_data", b_rsp_data, 32'd0);
            chk("rst_a_rsp_err", a_rsp_err, 0);
            chk("rst_b_rsp_err", b_rsp_err, 0);
            chk("rst_tx_tdata", spi_tx_tdata, 0);
            chk("rst_owner", stat_owner, 0);
        end
        if (areset) begin
            if (rst_q) chk("rx_tready_in_reset", spi_rx_tready, 0);
            m_fl = 0; m_xfer = 0; m_to = 0; m_stray = 0;
            exp_tx.delete(); rx_q.delete(); stray_q.delete();
            return;
        end
        chk("stat_busy", stat_busy, busy);
        chk("a_req_ready", a_req_ready, !busy);
        chk("b_req_ready", b_req_ready, !busy && !a_req_valid);
        chk("rx_tready", spi_rx_tready, 1);
        chk("timeout_cnt", stat_timeout_cnt, m_to);
        chk("stray_cnt", stat_stray_cnt, m_stray);
        if (busy) chk("stat_owner", stat_owner, m_port);
        if (m_xfer && cyc > t_acc) begin
            chk("tx_tvalid", spi_tx_tvalid, exp_tx.size() != 0);
            if (exp_tx.size() != 0) begin
                chk("tx_tdata", spi_tx_tdata, exp_tx[0]);
                if (tx_hs) begin void'(exp_tx.pop_front()); tx_sent++; end
            end
        end else begin
            chk("tx_tvalid_quiet", spi_tx_tvalid, 0);
        end
        if (rx_hs) begin
            if (m_xfer && cyc > t_acc) begin
                m_rsp = (m_rsp << 8) | 32'(spi_rx_tdata);
                rx_got++;
                void'(rx_q.pop_front());
                if (rx_got == m_n) begin m_xfer = 0; t_rsp = cyc + 1; m_err = 0; end
            end else begin
                if (m_stray < 255) m_stray++;
                if (stray_q.size() != 0) void'(stray_q.pop_front());
            end
        end
        if (m_xfer && cyc == t_acc + c_TIMEOUT) begin
            m_xfer = 0; t_rsp = cyc + 1; m_err = 1; m_rsp = 32'd0;
            exp_tx.delete(); rx_q.delete();
            if (m_to < 255) m_to++;
        end
        if (a_rsp_valid) pulses[0]++;
        if (b_rsp_valid) pulses[1]++;
        if (m_fl && !m_xfer && cyc == t_rsp) begin
            chk("rsp_valid_owner", (m_port != 0) ? b_rsp_valid : a_rsp_valid, 1);
            chk("rsp_valid_other", (m_port != 0) ? a_rsp_valid : b_rsp_valid, 0);
            chk("rsp_data", (m_port != 0) ? b_rsp_data : a_rsp_data, m_rsp);
            chk("rsp_err", (m_port != 0) ? b_rsp_err : a_rsp_err, m_err);
            exp_pulses[m_port]++;
            m_fl = 0;
        end else begin
            chk("a_rsp_valid_quiet", a_rsp_valid, 0);
            chk("b_rsp_valid_quiet", b_rsp_valid, 0);
        end
        if (!busy) begin
            if (a_req_valid) accept(0);
            else if (b_req_valid) accept(1);
        end
    endtask

    task automatic step();
        if (stall > 0) begin spi_tx_tready = 1'b0; stall--; end
        else spi_tx_tready = rnd_tready ? ($urandom_range(3) != 0) : 1'b1;
        if (m_xfer && rx_q.size() != 0 && rx_got < tx_sent && (!rnd_rx || $urandom_range(3) != 0)) begin
            spi_rx_tvalid = 1'b1; spi_rx_tdata = rx_q[0];
        end else if (!m_fl && !areset && !a_req_valid && !b_req_valid && stray_q.size() != 0) begin
            spi_rx_tvalid = 1'b1; spi_rx_tdata = stray_q[0];
        end else begin
            spi_rx_tvalid = 1'b0; spi_rx_tdata = 8'($urandom);
        end
        @(negedge aclk);
        observe();
        @(posedge aclk);
        #1;
        if (acc_a) a_req_valid = 1'b0;
        if (acc_b) b_req_valid = 1'b0;
        acc_a = 0; acc_b = 0;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        step();
        while ((m_fl || a_req_valid || b_req_valid) && k < limit) begin step(); k++; end
        chk("wait_bound_expired", 32'(m_fl || a_req_valid || b_req_valid), 0);
    endtask

    initial begin
        int k;
        repeat (3) step();
        areset = 1'b0;
        repeat (2) step();

        set_req(0, 2'd3, 32'hC400_0000, 32'h1122_3344, 1);
        a_req_valid = 1'b1;
        wait_idle(100);
        chk("t1_a_rsp_data", a_rsp_data, 32'h1122_3344);
        chk("t1_b_pulses", pulses[1], 0);

        set_req(1, 2'd2, 32'h00AB_CD12, 32'h0102_0300, 1);
        b_req_valid = 1'b1;
        wait_idle(100);
        chk("t2_b_rsp_data", b_rsp_data, 32'h0001_0203);

        set_req(0, 2'd1, 32'h0000_5A5A, 32'hA1A2_0000, 1);
        set_req(1, 2'd0, 32'h0000_0077, 32'hB100_0000, 1);
        a_req_valid = 1'b1; b_req_valid = 1'b1;
        wait_idle(200);
        chk("t3_a_rsp_data", a_rsp_data, 32'h0000_A1A2);
        chk("t3_b_rsp_data", b_rsp_data, 32'h0000_00B1);

        set_req(0, 2'd3, 32'hDEAD_BEEF, 32'h5566_7788, 1);
        a_req_valid = 1'b1;
        k = 0;
        while (tx_sent < 1 && k < 20) begin step(); k++; end
        stall = 3;
        wait_idle(100);
        chk("t4_a_rsp_data", a_rsp_data, 32'h5566_7788);

        set_req(0, 2'd1, 32'h0000_1234, 32'h0, 0);
        a_req_valid = 1'b1;
        wait_idle(100);
        chk("t5_timeout_cnt", stat_timeout_cnt, 1);
        chk("t5_a_rsp_err", a_rsp_err, 1);
        chk("t5_a_rsp_data", a_rsp_data, 32'd0);
        set_req(0, 2'd0, 32'h0000_0042, 32'h9900_0000, 1);
        a_req_valid = 1'b1;
        wait_idle(100);
        chk("t5_recover_err", a_rsp_err, 0);
        chk("t5_recover_data", a_rsp_data, 32'h0000_0099);

        stray_q.push_back(8'h3C); stray_q.push_back(8'hC3);
        repeat (4) step();
        chk("t6_stray_cnt", stat_stray_cnt, 2);

        set_req(1, 2'd3, 32'h0BAD_F00D, 32'h0102_0304, 1);
        b_req_valid = 1'b1;
        k = 0;
        while (tx_sent < 2 && k < 20) begin step(); k++; end
        areset = 1'b1;
        repeat (2) step();
        areset = 1'b0;
        repeat (4) step();
        chk("t7_stray_cnt", stat_stray_cnt, 0);
        chk("t7_timeout_cnt", stat_timeout_cnt, 0);

        rnd_tready = 1; rnd_rx = 1;
        for (int it = 0; it < 150; it++) begin
            int mode;
            mode = $urandom_range(2);
            set_req(0, 2'($urandom), $urandom, $urandom, 1);
            set_req(1, 2'($urandom), $urandom, $urandom, 1);
            if (mode != 1) a_req_valid = 1'b1;
            if (mode != 0) b_req_valid = 1'b1;
            wait_idle(400);
        end

        chk("a_pulse_total", pulses[0], exp_pulses[0]);
        chk("b_pulse_total", pulses[1], exp_pulses[1]);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: cycle %0d, %0d checks run", cyc, n_checks);
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire

// File: doc/ads868x_spi_arbiter.md
# ads868x_spi_arbiter

Shares the single ADS868x SPI byte-stream engine between two transaction requesters: port A (auto-sampling sequencer, fixed high priority) and port B (host register/command access). It frames 1–4 byte transactions onto the 8-bit AXI-Stream TX/RX interfaces of the SPI module and collects the returned bytes. It routes a 32-bit response to the requester that owns the transaction, and aborts on a watchdog timeout if RX bytes stop arriving. It sits between the ADS868x control logic and the SPI module.

## Interface
- C_TIMEOUT_CYCLES, default 4096: cycles allowed from transaction accept to last RX byte before abort (≥16).
- aclk  in  1  clock, single domain.
- areset  in  1  synchronous, active-high reset.
- a_req_valid / b_req_valid  in  1  transaction request.
- a_req_ready / b_req_ready  out  1  request accepted when valid&&ready.
- a_req_nbytes / b_req_nbytes  in  2  byte count minus one (3 = 4 bytes).
- a_req_data / b_req_data  in  32  TX payload, right-aligned; last byte sent is [7:0].
- a_rsp_data / b_rsp_data  out  32  RX bytes, right-aligned, unused upper bytes zero.
- a_rsp_valid / b_rsp_valid  out  1  one-cycle response pulse, no backpressure.
- a_rsp_err / b_rsp_err  out  1  qualifies rsp_valid: 1 = timeout abort.
- spi_tx_tdata / spi_tx_tvalid / spi_tx_tready  out/out/in  8/1/1  TX byte stream.
- spi_rx_tdata / spi_rx_tvalid / spi_rx_tready  in/in/out  8/1/1  RX byte stream.
- stat_busy  out  1  state ≠ S_IDLE.
- stat_owner  out  1  0 = A, 1 = B; owner of current/last transaction.
- stat_timeout_cnt  out  8  saturating count of timeouts.
- stat_stray_cnt  out  8  saturating count of RX bytes received outside S_XFER.

## Operation
- FSM: S_IDLE → S_XFER → S_RESP → S_IDLE. Any areset returns to S_IDLE.
- S_IDLE:
  - a_req_ready = 1.
  - b_req_ready = !a_req_valid. Both readies are combinational from the state register and a_req_valid.
  - If both request in the same cycle, A wins.
  - On accept: latch owner, n = nbytes+1, and tx_shift = req_data << 8*(4-n), so the first byte sent is the most significant of the n bytes. Clear rx_shift, tx/rx byte counters and watchdog; go to S_XFER.
- S_XFER:
  - spi_tx_tvalid = 1 while tx bytes sent < n; spi_tx_tdata = tx_shift[31:24].
  - On TX handshake, tx_shift shifts left 8 and the sent count increments. tdata/tvalid stay stable until tready.
  - Each RX beat: rx_shift = {rx_shift[23:0], spi_rx_tdata}; rx count increments.
  - When the n-th RX byte is accepted, go to S_RESP with err = 0.
  - Watchdog increments every S_XFER cycle. If it reaches C_TIMEOUT_CYCLES-1 without the n-th RX byte, abort:
    - go to S_RESP with err = 1 and response data 0;
    - spi_tx_tvalid drops immediately, even mid-beat;
    - stat_timeout_cnt increments, saturating at 255.
  - If the n-th RX byte arrives in the same cycle as the timeout, completion wins (err = 0).
- S_RESP: pulse the owner's rsp_valid for exactly one cycle with rsp_data/rsp_err, then return to S_IDLE. The other port's rsp_valid stays 0.
- spi_rx_tready = 1 in all states except during reset.
- RX beats accepted in S_IDLE or S_RESP are discarded and increment stat_stray_cnt, saturating at 255.
- rsp_data/rsp_err hold their last values between pulses.
- Mid-transaction areset: no response is emitted, and any partial transaction is dropped.

## Timing
- Reset values:
  - all *_rsp_data, *_rsp_valid, *_rsp_err = 0;
  - spi_tx_tvalid = 0, spi_tx_tdata = 0;
  - spi_rx_tready = 0 during reset, 1 from the first cycle after;
  - stat_busy = 0, stat_owner = 0, both stat counters = 0;
  - a_req_ready = 1, b_req_ready = !a_req_valid.
- Accept at cycle T: spi_tx_tvalid = 1 with the first byte at T+1; a_req_ready and b_req_ready = 0 from T+1.
- With tready held at 1, one TX byte per cycle (n bytes in n cycles). TX and RX progress independently.
- Last RX byte at cycle R: rsp_valid pulses at R+1, S_IDLE at R+2. The next request can be accepted at R+2.
- Timeout response pulses at T+C_TIMEOUT_CYCLES+1.

## Test plan
- A requests nbytes=3, data 0xC400_0000; SPI loopback returns 0x11,0x22,0x33,0x44 → TX bytes C4,00,00,00; a_rsp_data = 0x1122_3344, err = 0; b_rsp_valid stays 0.
- B requests nbytes=2, data 0x00AB_CD12; RX 0x01,0x02,0x03 → TX bytes AB,CD,12; b_rsp_data = 0x0001_0203.
- A and B assert valid in the same cycle → A is served first, then B is accepted 2 cycles after A's last RX byte; exactly one rsp pulse per port.
- Hold spi_tx_tready low for 3 cycles mid-transaction → tdata stays stable; sequence and response are unchanged.
- No RX bytes with C_TIMEOUT_CYCLES=16 → err = 1 and data = 0 at T+17; stat_timeout_cnt = 1; next request is accepted normally.
- Inject 2 RX bytes while idle → stat_stray_cnt = 2; no rsp pulse. Assert areset mid-transfer → all outputs return to reset values and no rsp pulse.
